// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared RS-232 FSM state encoding and the clogb2 helper
package rs232_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } rs232_state_t;

   // Bits needed to hold the value itself, so a counter can reach it inclusively.
   function automatic int clogb2(input int value);
      int w;
      w = 0;
      for (int v = value; v > 0; v = v >> 1) w++;
      if (w == 0) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/rs232_sync.sv
// rtl/rs232_sync.sv - two-flop synchronizer for the idle-high serial line
module rs232_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/rs232_deser.sv
// rtl/rs232_deser.sv - 8N1 deserializer into an RX FIFO; RS232_DES_PARITY_EN selects 8E1
module rs232_deser
   import rs232_pkg::*;
#(
   parameter int P_CLK_FREQ_HZ = 100000000,
   parameter int P_BAUD_RATE   = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_fifo_data,
   output logic       rx_fifo_wr_en,
   input  logic       rx_fifo_full,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err,
   output logic       busy
);

   localparam int BIT_CNT_MAX = P_CLK_FREQ_HZ / P_BAUD_RATE;
   localparam int HALF_CNT    = BIT_CNT_MAX / 2;
   localparam int CNT_W       = clogb2(BIT_CNT_MAX);
   localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(BIT_CNT_MAX);
   localparam logic [CNT_W-1:0] L_HALF = CNT_W'(HALF_CNT);

   rs232_state_t     r_state;
   rs232_state_t     w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic [7:0]       r_data;
   logic             r_wr_en;
   logic             r_frame_err;
   logic             r_overrun;
   logic             w_rx_s;
   logic             w_cnt_clr;
   logic             w_sample;
   logic             w_wr;
   logic             w_ferr;
   logic             w_ovr;
`ifdef RS232_DES_PARITY_EN
   logic             r_par_bad;
   logic             r_parity_err;
   logic             w_par_sample;
   logic             w_perr;
`endif

   rs232_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (rx),
      .o_q   (w_rx_s)
   );

   always_comb begin
      w_next    = r_state;
      w_cnt_clr = 1'b0;
      w_sample  = 1'b0;
      w_wr      = 1'b0;
      w_ferr    = 1'b0;
      w_ovr     = 1'b0;
`ifdef RS232_DES_PARITY_EN
      w_par_sample = 1'b0;
      w_perr       = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            w_cnt_clr = 1'b1;
            if (!w_rx_s) w_next = S_START;
         end
         S_START: begin
            // A start bit that is no longer low at half a bit was a glitch.
            if (r_cnt == L_HALF) begin
               w_cnt_clr = 1'b1;
               w_next    = w_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == L_MAX) begin
               w_cnt_clr = 1'b1;
               w_sample  = 1'b1;
`ifdef RS232_DES_PARITY_EN
               if (r_bit_cnt == 3'd7) w_next = S_PARITY;
`else
               if (r_bit_cnt == 3'd7) w_next = S_STOP;
`endif
            end
         end
`ifdef RS232_DES_PARITY_EN
         S_PARITY: begin
            if (r_cnt == L_MAX) begin
               w_cnt_clr    = 1'b1;
               w_par_sample = 1'b1;
               w_next       = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (r_cnt == L_MAX) begin
               w_cnt_clr = 1'b1;
               if (w_rx_s) begin
                  w_next = S_IDLE;
`ifdef RS232_DES_PARITY_EN
                  if (r_par_bad) w_perr = 1'b1;
                  else
`endif
                  if (rx_fifo_full) w_ovr = 1'b1;
                  else              w_wr  = 1'b1;
               end else begin
                  w_ferr = 1'b1;
                  w_next = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            w_cnt_clr = 1'b1;
            if (w_rx_s) w_next = S_IDLE;
         end
         default: begin
            w_cnt_clr = 1'b1;
            w_next    = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_wr_en     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef RS232_DES_PARITY_EN
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_state     <= w_next;
         r_cnt       <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
         r_wr_en     <= w_wr;
         r_frame_err <= w_ferr;
         r_overrun   <= w_ovr;
         if (r_state == S_IDLE) r_bit_cnt <= '0;
         else if (w_sample)     r_bit_cnt <= r_bit_cnt + 3'd1;
         if (w_sample) r_shift <= {w_rx_s, r_shift[7:1]};
         if (w_wr)     r_data  <= r_shift;
`ifdef RS232_DES_PARITY_EN
         // Even parity: the received bit must equal the XOR of the data bits.
         if (w_par_sample) r_par_bad <= w_rx_s ^ (^r_shift);
         r_parity_err <= w_perr;
`endif
      end
   end

   assign rx_fifo_data  = r_data;
   assign rx_fifo_wr_en = r_wr_en;
   assign frame_err     = r_frame_err;
   assign overrun       = r_overrun;
   assign busy          = (r_state != S_IDLE);
`ifdef RS232_DES_PARITY_EN
   assign parity_err    = r_parity_err;
`else
   assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_rs232_deser.sv
// tb/tb_rs232_deser.sv - scoreboard bench for rs232_deser (8N1, or 8E1 with RS232_DES_PARITY_EN)
module tb_rs232_deser;

   localparam int BIT_CLKS = 11;
`ifdef RS232_DES_PARITY_EN
   localparam int LAT_NOM  = 3 + 5 + 10 * BIT_CLKS;
`else
   localparam int LAT_NOM  = 3 + 5 + 9 * BIT_CLKS;
`endif
   localparam int K_WR   = 0;
   localparam int K_FERR = 1;
   localparam int K_OVR  = 2;
   localparam int K_PERR = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         t0;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       full = 1'b0;
   logic [7:0] rx_fifo_data;
   logic       rx_fifo_wr_en;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;
   logic       busy;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   rs232_deser #(
      .P_CLK_FREQ_HZ (1000000),
      .P_BAUD_RATE   (100000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx            (rx),
      .rx_fifo_data  (rx_fifo_data),
      .rx_fifo_wr_en (rx_fifo_wr_en),
      .rx_fifo_full  (full),
      .frame_err     (frame_err),
      .overrun       (overrun),
      .parity_err    (parity_err),
      .busy          (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic check_event(input int kind, input logic [7:0] data);
      exp_t e;
      int   lat;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event kind=%0d data=%02h", kind, data);
         return;
      end
      e = q.pop_front();
      if (e.kind != kind || (kind == K_WR && e.data !== data)) begin
         errors++;
         $display("FAIL event got kind=%0d data=%02h exp kind=%0d data=%02h", kind, data, e.kind, e.data);
      end
      lat = cyc - e.t0;
      checks++;
      if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
         errors++;
         $display("FAIL latency got=%0d exp=%0d+-1", lat, LAT_NOM);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_fifo_wr_en) check_event(K_WR, rx_fifo_data);
         if (frame_err)     check_event(K_FERR, 8'h00);
         if (overrun)       check_event(K_OVR, 8'h00);
         if (parity_err)    check_event(K_PERR, 8'h00);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int kind);
      exp_t e;
      rx = 1'b0;
      e.kind = kind;
      e.data = d;
      e.t0   = cyc;
      q.push_back(e);
      idle(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         idle(BIT_CLKS);
      end
`ifdef RS232_DES_PARITY_EN
      rx = par;
      idle(BIT_CLKS);
`endif
      rx = stop;
      idle(BIT_CLKS);
   endtask

   initial begin
      logic [7:0] ab;
      rst_n = 1'b0;
      rx    = 1'b1;
      full  = 1'b0;
      idle(3);
      check("reset_wr_en", rx_fifo_wr_en, 0);
      check("reset_data", rx_fifo_data, 0);
      check("reset_frame_err", frame_err, 0);
      check("reset_overrun", overrun, 0);
      check("reset_parity_err", parity_err, 0);
      check("reset_busy", busy, 0);
      rst_n = 1'b1;
      idle(5);

      send_frame(8'hA5, 1'b0, 1'b1, K_WR);
      send_frame(8'h3C, 1'b0, 1'b1, K_WR);
      idle(20);
      check("b2b_queue_empty", q.size(), 0);

      rx = 1'b0;
      idle(2);
      rx = 1'b1;
      idle(1);
      check("glitch_busy_high", busy, 1);
      idle(7);
      check("glitch_busy_low", busy, 0);
      idle(20);

      send_frame(8'h55, 1'b0, 1'b0, K_FERR);
      idle(50);
      check("break_busy_high", busy, 1);
      check("break_queue_empty", q.size(), 0);
      rx = 1'b1;
      idle(4);
      check("break_busy_low", busy, 0);
      idle(20);

      full = 1'b1;
      send_frame(8'h81, 1'b0, 1'b1, K_OVR);
      full = 1'b0;
      send_frame(8'h7E, 1'b0, 1'b1, K_WR);
      idle(20);
      check("overrun_queue_empty", q.size(), 0);

      ab = 8'h12;
      rx = 1'b0;
      idle(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         rx = ab[i];
         idle(BIT_CLKS);
      end
      rx = ab[4];
      idle(5);
      rst_n = 1'b0;
      #1;
      check("midreset_busy", busy, 0);
      check("midreset_wr_en", rx_fifo_wr_en, 0);
      check("midreset_data", rx_fifo_data, 0);
      check("midreset_frame_err", frame_err, 0);
      check("midreset_overrun", overrun, 0);
      check("midreset_parity_err", parity_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rx    = 1'b1;
      idle(15);
      send_frame(8'h12, 1'b0, 1'b1, K_WR);
      idle(20);
      check("midreset_queue_empty", q.size(), 0);

`ifdef RS232_DES_PARITY_EN
      send_frame(8'h07, 1'b0, 1'b1, K_PERR);
      send_frame(8'h07, 1'b1, 1'b1, K_WR);
      idle(20);
      check("parity_queue_empty", q.size(), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL timeout cycles=%0d", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
